line_fill_responder: RTL and testbench
======================================

LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: memory word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter BLOCK_SIZE, default 32: cache line size in bytes; WORDS = BLOCK_SIZE/(DATA_WIDTH/8) SHALL be a power of two, >= 2.
REQ-003 Parameter ADDRESS_WIDTH, default 32: byte address width; OFFSET_WIDTH = $clog2(WORDS).
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 fetch_request  in  1  level request from cache controller; held until line_fill_valid seen.
REQ-007 fetch_address  in  ADDRESS_WIDTH  byte address of missing line; low $clog2(BLOCK_SIZE) bits ignored.
REQ-008 fetch_offset  in  OFFSET_WIDTH  critical word index; used only when the macro in REQ-030 is defined.
REQ-009 line_fill_valid  out  1  assembled line available on line_data.
REQ-010 line_data  out  BLOCK_SIZE*8  assembled line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 mem_req_valid  out  1  read beat request to backing memory.
REQ-012 mem_req_ready  in  1  memory accepts request when high with mem_req_valid.
REQ-013 mem_req_addr  out  ADDRESS_WIDTH  byte address of requested word.
REQ-014 mem_rsp_valid  in  1  read data valid, one response per accepted request, in order.
REQ-015 mem_rsp_data  in  DATA_WIDTH  read data.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT_RSP, DONE.
REQ-018 IDLE: on fetch_request=1 latch base = fetch_address with low $clog2(BLOCK_SIZE) bits zeroed, beat index idx = 0, beat count = 0, abort flag = 0; next state REQ.
REQ-019 REQ: mem_req_valid=1, mem_req_addr = base + idx*(DATA_WIDTH/8); on mem_req_valid & mem_req_ready go WAIT_RSP.
REQ-020 Once asserted, mem_req_valid and mem_req_addr SHALL stay stable until handshake, regardless of fetch_request.
REQ-021 WAIT_RSP: on mem_rsp_valid write mem_rsp_data to line_data slot idx, idx = (idx+1) mod WORDS, count+1; if count was WORDS-1 go DONE, else REQ.
REQ-022 mem_rsp_valid outside WAIT_RSP SHALL be ignored, no state or data change.
REQ-023 DONE: line_fill_valid=1 and line_data stable; go IDLE on the first cycle fetch_request=0; line_fill_valid low in all other states.
REQ-024 fetch_request=0 sampled in REQ or WAIT_RSP SHALL set abort flag; the in-flight beat completes (request handshake then its response), then state goes IDLE directly, skipping DONE, no line_fill_valid.
REQ-025 Latency: ready always high, response one cycle after handshake, WORDS=8 -> line_fill_valid high 16 cycles after the edge sampling fetch_request in IDLE.
REQ-026 line_data SHALL retain contents between fetches; unwritten slots keep previous values.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH; no carry into base beyond line span.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, line_fill_valid=0, mem_req_valid=0, mem_req_addr=0, busy=0, line_data=0, idx=0, count=0, abort=0.
REQ-029 Reset mid-fetch SHALL discard partial line; responses arriving after release in IDLE are ignored per REQ-022.

Configuration
REQ-030 Macro LINE_FILL_CRITICAL_WORD_FIRST_EN defined: IDLE latches idx = fetch_offset, beats issue fetch_offset, +1, ... wrapping mod WORDS; slot placement by absolute index unchanged. Undefined: idx starts at 0, fetch_offset ignored.

Verification
REQ-031 fetch_address=0x0000_1234, ready=1, rsp one cycle later with data 0xA0+i -> addrs 0x1220..0x123C step 4, line_data word i=0xA0+i, line_fill_valid at cycle 16, held until fetch_request drops, then IDLE.
REQ-032 mem_req_ready low 3 cycles on beat 2 -> mem_req_valid/addr 0x1228 stable throughout, completion delayed exactly 3 cycles.
REQ-033 fetch_request dropped during beat 4 WAIT_RSP -> beat 4 completes, IDLE next, line_fill_valid never asserts, busy=0.
REQ-034 Spurious mem_rsp_valid=1 data 0xDEAD in IDLE and DONE -> line_data unchanged.
REQ-035 reset_n pulsed low during beat 5 -> all outputs at reset values same cycle; new fetch after release starts at word 0.
REQ-036 Macro defined, fetch_offset=6 -> addr order 0x1238,0x123C,0x1220..0x1234, line_data identical to REQ-031 layout.

Source files
------------

// File: rtl/line_fill_responder_if.sv
// line_fill_responder_if: cache-side fetch and backing-memory read signals of the line fill responder
interface line_fill_responder_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int BLOCK_SIZE    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   localparam int WORDS        = BLOCK_SIZE / (DATA_WIDTH / 8);
   localparam int OFFSET_WIDTH = $clog2(WORDS);
   logic                     fetch_request;
   logic [ADDRESS_WIDTH-1:0] fetch_address;
   logic [OFFSET_WIDTH-1:0]  fetch_offset;
   logic                     line_fill_valid;
   logic [BLOCK_SIZE*8-1:0]  line_data;
   logic                     mem_req_valid;
   logic                     mem_req_ready;
   logic [ADDRESS_WIDTH-1:0] mem_req_addr;
   logic                     mem_rsp_valid;
   logic [DATA_WIDTH-1:0]    mem_rsp_data;
   logic                     busy;
   modport slave (
      input  fetch_request, fetch_address, fetch_offset, mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output line_fill_valid, line_data, mem_req_valid, mem_req_addr, busy
   );
   modport master (
      output fetch_request, fetch_address, fetch_offset, mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  line_fill_valid, line_data, mem_req_valid, mem_req_addr, busy
   );
endinterface

// File: rtl/line_fill_responder.sv
// line_fill_responder: fetches a cache line one word per beat and presents it assembled; LINE_FILL_CRITICAL_WORD_FIRST_EN starts at fetch_offset
module line_fill_responder #(
   parameter int DATA_WIDTH    = 32,
   parameter int BLOCK_SIZE    = 32,
   parameter int ADDRESS_WIDTH = 32
) (
   input logic                  clk,
   input logic                  reset_n,
   line_fill_responder_if.slave bus
);
   localparam int BYTES        = DATA_WIDTH / 8;
   localparam int WORDS        = BLOCK_SIZE / BYTES;
   localparam int OFFSET_WIDTH = $clog2(WORDS);
   localparam int BYTE_BITS    = $clog2(BYTES);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
   state_t                   state, state_next;
   logic [ADDRESS_WIDTH-1:0] base;
   logic [OFFSET_WIDTH-1:0]  idx, count;
   logic                     abort, abort_next;
   logic [BLOCK_SIZE*8-1:0]  line;
   // an abort sticks once the requester lets go during a beat
   always_comb abort_next = abort | ~bus.fetch_request;
   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_next;
   // next state: every beat is a request handshake then one response
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     state_next = bus.fetch_request ? REQ : IDLE;
         REQ:      state_next = bus.mem_req_ready ? WAIT_RSP : REQ;
         WAIT_RSP: state_next = !bus.mem_rsp_valid ? WAIT_RSP : abort_next ? IDLE :
                                count == OFFSET_WIDTH'(WORDS - 1) ? DONE : REQ;
         default:  state_next = bus.fetch_request ? DONE : IDLE;
      endcase
   end
   // line base, beat index/count, abort flag and assembled line
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         base  <= '0;
         idx   <= '0;
         count <= '0;
         abort <= 1'b0;
         line  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.fetch_request) begin
               base  <= bus.fetch_address & ~ADDRESS_WIDTH'(BLOCK_SIZE - 1);
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
               idx   <= bus.fetch_offset;
`else
               idx   <= '0;
`endif
               count <= '0;
               abort <= 1'b0;
            end
            REQ: abort <= abort_next;
            WAIT_RSP: begin
               abort <= abort_next;
               if (bus.mem_rsp_valid) begin
                  line[idx*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rsp_data;
                  idx   <= idx + 1'b1;
                  count <= count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   // outputs decoded from state; address is base plus beat offset and never carries out of the line
   always_comb begin
      bus.mem_req_valid   = state == REQ;
      bus.line_fill_valid = state == DONE;
      bus.busy            = state != IDLE;
      bus.mem_req_addr    = base | (ADDRESS_WIDTH'(idx) << BYTE_BITS);
      bus.line_data       = line;
   end
endmodule

// File: tb/tb_line_fill_responder.sv
// tb_line_fill_responder: directed and randomized line fills checked against a word-array model
module tb_line_fill_responder;
   localparam int DW    = 32;
   localparam int BS    = 32;
   localparam int AW    = 32;
   localparam int WORDS = BS / (DW / 8);
   localparam int OW    = $clog2(WORDS);
   localparam int LW    = BS * 8;
   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   int            n_assert = 0;
   int            n_fail = 0;
   logic [DW-1:0] model [WORDS];
   line_fill_responder_if #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW)) bus ();
   line_fill_responder #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [LW-1:0] model_line();
      logic [LW-1:0] l;
      for (int i = 0; i < WORDS; i++) l[i*DW +: DW] = model[i];
      return l;
   endfunction
   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic check_reset(input string tag);
      check({tag, "_busy"}, LW'(bus.busy), '0);
      check({tag, "_fill_valid"}, LW'(bus.line_fill_valid), '0);
      check({tag, "_req_valid"}, LW'(bus.mem_req_valid), '0);
      check({tag, "_req_addr"}, LW'(bus.mem_req_addr), '0);
      check({tag, "_line"}, bus.line_data, '0);
   endtask
   task automatic run_fetch(input logic [AW-1:0] addr, input int off, input int stall_beat,
                            input int stall_len, input int drop_beat, input int rst_beat);
      logic [AW-1:0] base;
      logic [DW-1:0] d;
      int start, slot, cycles, stalls;
      base = addr & ~AW'(BS - 1);
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
      start = off;
`else
      start = 0;
`endif
      stalls = 0;
      bus.fetch_request = 1'b1;
      bus.fetch_address = addr;
      bus.fetch_offset  = OW'(off);
      @(negedge clk);
      cycles = 0;
      check("busy_after_start", LW'(bus.busy), LW'(1));
      for (int b = 0; b < WORDS; b++) begin
         slot = (start + b) % WORDS;
         for (int s = 0; s <= (b == stall_beat ? stall_len : 0); s++) begin
            check("req_valid", LW'(bus.mem_req_valid), LW'(1));
            check("req_addr", LW'(bus.mem_req_addr), LW'(base + AW'(slot * (DW / 8))));
            bus.mem_req_ready = (b == stall_beat && s < stall_len) ? 1'b0 : 1'b1;
            if (b == stall_beat && s < stall_len) stalls++;
            @(negedge clk);
            cycles++;
         end
         bus.mem_req_ready = 1'b0;
         d = DW'($urandom);
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = d;
         check("wait_no_req", LW'(bus.mem_req_valid), '0);
         if (b == rst_beat) begin
            reset_n = 1'b0;
            #1;
            foreach (model[i]) model[i] = '0;
            check_reset("mid_reset");
            @(negedge clk);
            reset_n = 1'b1;
            bus.fetch_request = 1'b0;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            check("post_reset_busy", LW'(bus.busy), '0);
            check("post_reset_line", bus.line_data, model_line());
            return;
         end
         if (b == drop_beat) bus.fetch_request = 1'b0;
         @(negedge clk);
         cycles++;
         bus.mem_rsp_valid = 1'b0;
         model[slot] = d;
         if (b == drop_beat) begin
            check("abort_busy", LW'(bus.busy), '0);
            check("abort_fill_valid", LW'(bus.line_fill_valid), '0);
            @(negedge clk);
            check("abort_still_idle", LW'(bus.busy | bus.line_fill_valid), '0);
            check("abort_line", bus.line_data, model_line());
            return;
         end
      end
      check("latency", LW'(cycles), LW'(2 * WORDS + stalls));
      check("fill_valid", LW'(bus.line_fill_valid), LW'(1));
      check("line_data", bus.line_data, model_line());
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD;
      repeat (2) @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      check("done_hold_valid", LW'(bus.line_fill_valid), LW'(1));
      check("done_spurious_line", bus.line_data, model_line());
      bus.fetch_request = 1'b0;
      @(negedge clk);
      check("release_fill_valid", LW'(bus.line_fill_valid), '0);
      check("release_busy", LW'(bus.busy), '0);
   endtask
   initial begin
      foreach (model[i]) model[i] = '0;
      bus.fetch_request = 1'b0;
      bus.fetch_address = '0;
      bus.fetch_offset  = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      repeat (2) @(negedge clk);
      check_reset("por");
      reset_n = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD;
      repeat (2) @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      check("idle_spurious_busy", LW'(bus.busy), '0);
      check("idle_spurious_line", bus.line_data, model_line());
      run_fetch(32'h0000_1234, 6, -1, 0, -1, -1);
      run_fetch(32'h0000_1234, 0, 2, 3, -1, -1);
      run_fetch(AW'($urandom), $urandom_range(WORDS - 1), -1, 0, 4, -1);
      run_fetch(AW'($urandom), 0, -1, 0, -1, 5);
      run_fetch(AW'($urandom), 0, -1, 0, -1, -1);
      run_fetch(32'hFFFF_FFFF, $urandom_range(WORDS - 1), $urandom_range(WORDS - 1), 2, -1, -1);
      for (int k = 0; k < 6; k++)
         run_fetch(AW'($urandom), $urandom_range(WORDS - 1), $urandom_range(WORDS - 1),
                   $urandom_range(3), -1, -1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
